// File: rtl/udp_echo_buf_app.sv
// Buffered UDP echo app: filters RX packets on destination port, queues headers and
// payload in independent FIFOs, and replays them with swapped addresses and ports.
`ifndef IP_ADDR_W
`define IP_ADDR_W 32
`endif
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 512
`endif
`ifndef UDP_ECHO_TYPES_DEFINED
`define UDP_ECHO_TYPES_DEFINED
typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] length;
    logic [15:0] chksum;
} udp_pkt_hdr;
typedef struct packed {
    logic [63:0] timestamp;
} tracker_stats_struct;
`endif

module udp_echo_buf_app #(
    parameter int          DATA_W          = `MAC_INTERFACE_W,
    parameter int          PAD_W           = $clog2(DATA_W/8),
    parameter int          HDR_FIFO_DEPTH  = 4,
    parameter int          DATA_FIFO_DEPTH = 64,
    parameter bit          FILTER_EN       = 1'b1,
    parameter logic [15:0] ECHO_PORT       = 16'd7,
    parameter int          CNT_W           = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   src_udp_echo_app_rx_hdr_val,
    input  logic [`IP_ADDR_W-1:0]  src_udp_echo_app_rx_src_ip,
    input  logic [`IP_ADDR_W-1:0]  src_udp_echo_app_rx_dst_ip,
    input  udp_pkt_hdr             src_udp_echo_app_rx_udp_hdr,
    input  tracker_stats_struct    src_udp_echo_app_rx_timestamp,
    output logic                   udp_echo_app_src_rx_hdr_rdy,
    input  logic                   src_udp_echo_app_rx_data_val,
    input  logic [DATA_W-1:0]      src_udp_echo_app_rx_data,
    input  logic                   src_udp_echo_app_rx_last,
    input  logic [PAD_W-1:0]       src_udp_echo_app_rx_padbytes,
    output logic                   udp_echo_app_src_rx_data_rdy,
    output logic                   udp_echo_app_dst_hdr_val,
    output logic [`IP_ADDR_W-1:0]  udp_echo_app_dst_src_ip_addr,
    output logic [`IP_ADDR_W-1:0]  udp_echo_app_dst_dst_ip_addr,
    output udp_pkt_hdr             udp_echo_app_dst_udp_hdr,
    output tracker_stats_struct    udp_echo_app_dst_timestamp,
    input  logic                   dst_udp_echo_app_hdr_rdy,
    output logic                   udp_echo_app_dst_data_val,
    output logic [DATA_W-1:0]      udp_echo_app_dst_data,
    output logic                   udp_echo_app_dst_data_last,
    output logic [PAD_W-1:0]       udp_echo_app_dst_data_padbytes,
    input  logic                   dst_udp_echo_app_data_rdy,
    output logic                   app_stats_do_log,
    output logic                   app_stats_incr_bytes_sent,
    output logic [PAD_W:0]         app_stats_num_bytes_sent,
    output logic [CNT_W-1:0]       pkts_echoed,
    output logic [CNT_W-1:0]       pkts_dropped
);
    localparam int HAW = $clog2(HDR_FIFO_DEPTH);
    localparam int DAW = $clog2(DATA_FIFO_DEPTH);
    localparam logic [PAD_W:0]   BEAT_BYTES = (PAD_W+1)'(DATA_W/8);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [`IP_ADDR_W-1:0] src_ip;
        logic [`IP_ADDR_W-1:0] dst_ip;
        udp_pkt_hdr            udp;
        tracker_stats_struct   ts;
    } hdr_ent_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [PAD_W-1:0]  pad;
    } data_ent_t;

    typedef enum logic [1:0] {RX_HDR, RX_DATA, RX_DROP} rx_state_e;

    rx_state_e        state_q;
    hdr_ent_t         hdr_mem  [HDR_FIFO_DEPTH];
    data_ent_t        data_mem [DATA_FIFO_DEPTH];
    logic [HAW:0]     hdr_wr_q, hdr_wr_d, hdr_rd_q, hdr_rd_d;
    logic [DAW:0]     data_wr_q, data_wr_d, data_rd_q, data_rd_d;
    logic [CNT_W-1:0] echoed_q, dropped_q;
    logic             do_log_q;
    logic             hdr_full, hdr_empty, data_full, data_empty;
    logic             rx_hdr_xfer, rx_data_xfer, hdr_match;
    logic             hdr_push, hdr_pop, data_push, data_pop;
    hdr_ent_t         hdr_in, hdr_head;
    data_ent_t        data_in, data_head;

    assign hdr_empty  = (hdr_wr_q == hdr_rd_q);
    assign hdr_full   = (hdr_wr_q[HAW] != hdr_rd_q[HAW]) && (hdr_wr_q[HAW-1:0] == hdr_rd_q[HAW-1:0]);
    assign data_empty = (data_wr_q == data_rd_q);
    assign data_full  = (data_wr_q[DAW] != data_rd_q[DAW]) && (data_wr_q[DAW-1:0] == data_rd_q[DAW-1:0]);

    // Handshake outputs are gated by rst so they read 0 on the very first reset cycle.
    assign udp_echo_app_src_rx_hdr_rdy  = !rst && (state_q == RX_HDR) && !hdr_full;
    assign udp_echo_app_src_rx_data_rdy = !rst && (((state_q == RX_DATA) && !data_full) || (state_q == RX_DROP));
    assign udp_echo_app_dst_hdr_val     = !rst && !hdr_empty;
    assign udp_echo_app_dst_data_val    = !rst && !data_empty;

    assign rx_hdr_xfer  = src_udp_echo_app_rx_hdr_val && udp_echo_app_src_rx_hdr_rdy;
    assign rx_data_xfer = src_udp_echo_app_rx_data_val && udp_echo_app_src_rx_data_rdy;
    assign hdr_match    = !FILTER_EN || (src_udp_echo_app_rx_udp_hdr.dst_port == ECHO_PORT);
    assign hdr_push     = rx_hdr_xfer && hdr_match;
    assign data_push    = rx_data_xfer && (state_q == RX_DATA);
    assign hdr_pop      = udp_echo_app_dst_hdr_val && dst_udp_echo_app_hdr_rdy;
    assign data_pop     = udp_echo_app_dst_data_val && dst_udp_echo_app_data_rdy;

    assign hdr_wr_d  = hdr_wr_q  + {{HAW{1'b0}}, hdr_push};
    assign hdr_rd_d  = hdr_rd_q  + {{HAW{1'b0}}, hdr_pop};
    assign data_wr_d = data_wr_q + {{DAW{1'b0}}, data_push};
    assign data_rd_d = data_rd_q + {{DAW{1'b0}}, data_pop};

    always_comb begin
        hdr_in              = '0;
        hdr_in.src_ip       = src_udp_echo_app_rx_dst_ip;
        hdr_in.dst_ip       = src_udp_echo_app_rx_src_ip;
        hdr_in.udp.src_port = src_udp_echo_app_rx_udp_hdr.dst_port;
        hdr_in.udp.dst_port = src_udp_echo_app_rx_udp_hdr.src_port;
        hdr_in.udp.length   = src_udp_echo_app_rx_udp_hdr.length;
        hdr_in.ts           = src_udp_echo_app_rx_timestamp;
    end

    assign data_in = {src_udp_echo_app_rx_data, src_udp_echo_app_rx_last, src_udp_echo_app_rx_padbytes};

    always_ff @(posedge clk) begin
        if (hdr_push)  hdr_mem[hdr_wr_q[HAW-1:0]]   <= hdr_in;
        if (data_push) data_mem[data_wr_q[DAW-1:0]] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_wr_q  <= '0;
            hdr_rd_q  <= '0;
            data_wr_q <= '0;
            data_rd_q <= '0;
        end else begin
            hdr_wr_q  <= hdr_wr_d;
            hdr_rd_q  <= hdr_rd_d;
            data_wr_q <= data_wr_d;
            data_rd_q <= data_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RX_HDR;
            echoed_q  <= '0;
            dropped_q <= '0;
            do_log_q  <= 1'b0;
        end else begin
            case (state_q)
                RX_HDR: if (rx_hdr_xfer) begin
                    do_log_q <= 1'b1;
                    if (hdr_match) begin
                        state_q  <= RX_DATA;
                        echoed_q <= echoed_q + CNT_ONE;
                    end else begin
                        state_q   <= RX_DROP;
                        dropped_q <= dropped_q + CNT_ONE;
                    end
                end
                RX_DATA, RX_DROP: if (rx_data_xfer && src_udp_echo_app_rx_last) state_q <= RX_HDR;
                default: state_q <= RX_HDR;
            endcase
        end
    end

    assign hdr_head  = hdr_mem[hdr_rd_q[HAW-1:0]];
    assign data_head = data_mem[data_rd_q[DAW-1:0]];

    assign udp_echo_app_dst_src_ip_addr   = hdr_head.src_ip;
    assign udp_echo_app_dst_dst_ip_addr   = hdr_head.dst_ip;
    assign udp_echo_app_dst_udp_hdr       = hdr_head.udp;
    assign udp_echo_app_dst_timestamp     = hdr_head.ts;
    assign udp_echo_app_dst_data          = data_head.data;
    assign udp_echo_app_dst_data_last     = data_head.last;
    assign udp_echo_app_dst_data_padbytes = data_head.pad;

    assign app_stats_do_log          = do_log_q;
    assign app_stats_incr_bytes_sent = data_pop;
    assign app_stats_num_bytes_sent  = data_head.last ? (BEAT_BYTES - {1'b0, data_head.pad}) : BEAT_BYTES;
    assign pkts_echoed               = echoed_q;
    assign pkts_dropped              = dropped_q;
endmodule
